pa_sysmap_regs_nch: RTL and testbench

Parametrised N-region system-map register file with an integrated address-lookup pipeline. Each region holds a 4 KB-granular upper-bound address, a 3-bit attribute field and a sticky lock bit. Regions load from pads on the reset-sample pulse and are then programmed over the sysmap bus interface. A one-cycle registered lookup port returns the attribute of the first region whose bound exceeds a fetch/load-store address. It sits between the sysmap bus decoder and the IFU/LSU attribute checkers, and replaces per-region single-register instances.

---
 rtl/pa_sysmap_pkg.sv | 16 +
 rtl/pa_sysmap_region_entry.sv | 56 +++++
 rtl/pa_sysmap_regs_nch.sv | 145 ++++++++++++++
 tb/tb_pa_sysmap_regs_nch.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_sysmap_pkg.sv
// Shared constants and the region record for the sysmap register file.
// Flag word layout: lock at bit 7, attribute at bits [4:2].
package pa_sysmap_pkg;
   localparam int   FLG_LOCK_BIT  = 7;
   localparam int   FLG_ATTR_LSB  = 2;
   localparam int   REGION_ADDR_W = 20;
   localparam int   REGION_ATTR_W = 3;
   localparam logic SEL_BASE      = 1'b0;
   localparam logic SEL_FLG       = 1'b1;

   typedef struct packed {
      logic [REGION_ADDR_W-1:0] base;
      logic [REGION_ATTR_W-1:0] attr;
      logic                     lock;
   } sysmap_region_t;
endpackage

// File: rtl/pa_sysmap_region_entry.sv
// One sysmap region: bound/attribute/lock registers, pad load, locked write
// handling and the "lookup address below bound" compare.
module pa_sysmap_region_entry
   import pa_sysmap_pkg::*;
#(
   parameter int ADDR_WIDTH = 20,
   parameter int ATTR_WIDTH = 3
) (
   input  logic                  sysmap_clk,
   input  logic                  cpurst,
   input  logic                  rst_sample,
   input  logic [ADDR_WIDTH-1:0] pad_addr,
   input  logic [ATTR_WIDTH-1:0] pad_attr,
   input  logic                  wr_en,
   input  logic                  wr_sel,
   input  logic [31:0]           wdata,
   input  logic [ADDR_WIDTH-1:0] lookup_addr,
   output logic [ADDR_WIDTH-1:0] base,
   output logic [ATTR_WIDTH-1:0] attr,
   output logic                  lock,
   output logic                  addr_below
);

   logic [ADDR_WIDTH-1:0] base_reg;
   logic [ATTR_WIDTH-1:0] attr_reg;
   logic                  lock_reg;
   logic                  unused_wdata;

   // Pad sample outranks any bus write; a locked region ignores writes.
   always_ff @(posedge sysmap_clk or posedge cpurst) begin
      if (cpurst) begin
         base_reg <= '0;
         attr_reg <= '0;
         lock_reg <= 1'b0;
      end else if (rst_sample) begin
         base_reg <= pad_addr;
         attr_reg <= pad_attr;
         lock_reg <= 1'b0;
      end else if (wr_en && !lock_reg) begin
         if (wr_sel == SEL_BASE) begin
            base_reg <= wdata[ADDR_WIDTH-1:0];
         end else begin
            attr_reg <= wdata[FLG_ATTR_LSB +: ATTR_WIDTH];
            lock_reg <= wdata[FLG_LOCK_BIT];
         end
      end
   end

   assign unused_wdata = ^wdata[31:ADDR_WIDTH];

   assign base       = base_reg;
   assign attr       = attr_reg;
   assign lock       = lock_reg;
   assign addr_below = (lookup_addr < base_reg);

endmodule

// File: rtl/pa_sysmap_regs_nch.sv
// N-region sysmap register file: bus read/write with lock protection and a
// one-cycle registered attribute lookup (first region whose bound exceeds addr).
module pa_sysmap_regs_nch
   import pa_sysmap_pkg::*;
#(
   parameter int                  NUM_REGION = 8,
   parameter int                  ADDR_WIDTH = 20,
   parameter int                  ATTR_WIDTH = 3,
   parameter logic [ATTR_WIDTH-1:0] DFLT_ATTR = 3'b000,
   localparam int                 IDX_W      = $clog2(NUM_REGION)
) (
   input  logic                             sysmap_clk,
   input  logic                             cpurst,
   input  logic                             ifu_sysmap_rst_sample,
   input  logic [NUM_REGION*ADDR_WIDTH-1:0] pad_cpu_sysmap_addr,
   input  logic [NUM_REGION*ATTR_WIDTH-1:0] pad_cpu_sysmap_attr,
   input  logic                             busif_wr_vld,
   input  logic [IDX_W-1:0]                 busif_wr_idx,
   input  logic                             busif_wr_sel,
   input  logic [31:0]                      busif_wdata,
   input  logic                             busif_rd_vld,
   input  logic [IDX_W-1:0]                 busif_rd_idx,
   input  logic                             busif_rd_sel,
   output logic [31:0]                      busif_rdata,
   output logic                             busif_rd_done,
   output logic                             busif_wr_err,
   input  logic                             lookup_vld,
   input  logic [ADDR_WIDTH-1:0]            lookup_addr,
   output logic                             lookup_rslt_vld,
   output logic [ATTR_WIDTH-1:0]            lookup_rslt_attr,
   output logic                             lookup_rslt_hit,
   output logic [IDX_W-1:0]                 lookup_rslt_idx,
   output logic [NUM_REGION*ADDR_WIDTH-1:0] sysmap_base_addr_value,
   output logic [NUM_REGION*5-1:0]          sysmap_flg_value
);

   logic [ADDR_WIDTH-1:0] base_arr [NUM_REGION];
   logic [ATTR_WIDTH-1:0] attr_arr [NUM_REGION];
   logic [NUM_REGION-1:0] lock_vec;
   logic [NUM_REGION-1:0] below_vec;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGION; gi++) begin : g_region
         pa_sysmap_region_entry #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .ATTR_WIDTH (ATTR_WIDTH)
         ) u_entry (
            .sysmap_clk  (sysmap_clk),
            .cpurst      (cpurst),
            .rst_sample  (ifu_sysmap_rst_sample),
            .pad_addr    (pad_cpu_sysmap_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]),
            .pad_attr    (pad_cpu_sysmap_attr[gi*ATTR_WIDTH +: ATTR_WIDTH]),
            .wr_en       (busif_wr_vld && (busif_wr_idx == IDX_W'(gi))),
            .wr_sel      (busif_wr_sel),
            .wdata       (busif_wdata),
            .lookup_addr (lookup_addr),
            .base        (base_arr[gi]),
            .attr        (attr_arr[gi]),
            .lock        (lock_vec[gi]),
            .addr_below  (below_vec[gi])
         );
         assign sysmap_base_addr_value[gi*ADDR_WIDTH +: ADDR_WIDTH] = base_arr[gi];
         assign sysmap_flg_value[gi*5 +: 5] = {attr_arr[gi], 2'b00};
      end
   endgenerate

   logic                  wr_idx_oor;
   logic                  wr_lock_hit;
   logic                  wr_err_next;
   logic [31:0]           rdata_next;
   logic                  hit_next;
   logic [IDX_W-1:0]      idx_next;
   logic [ATTR_WIDTH-1:0] attr_next;

   assign wr_idx_oor  = ({1'b0, busif_wr_idx} >= (IDX_W+1)'(NUM_REGION));
   assign wr_err_next = busif_wr_vld && !ifu_sysmap_rst_sample && (wr_idx_oor || wr_lock_hit);

   always_comb begin
      wr_lock_hit = 1'b0;
      rdata_next  = '0;
      for (int i = 0; i < NUM_REGION; i++) begin
         if (busif_wr_idx == IDX_W'(i)) wr_lock_hit = lock_vec[i];
         if (busif_rd_idx == IDX_W'(i)) begin
            if (busif_rd_sel == SEL_FLG)
               rdata_next = 32'({lock_vec[i], 2'b00, attr_arr[i], 2'b00});
            else
               rdata_next = 32'(base_arr[i]);
         end
      end
   end

   // Walk from the top so the lowest-numbered below-bound region wins.
   always_comb begin
      hit_next  = 1'b0;
      idx_next  = '0;
      attr_next = DFLT_ATTR;
      for (int i = NUM_REGION-1; i >= 0; i--) begin
         if (below_vec[i]) begin
            hit_next  = 1'b1;
            idx_next  = IDX_W'(i);
            attr_next = attr_arr[i];
         end
      end
   end

   logic [31:0]           rdata_reg;
   logic                  rd_done_reg;
   logic                  wr_err_reg;
   logic                  rslt_vld_reg;
   logic [ATTR_WIDTH-1:0] rslt_attr_reg;
   logic                  rslt_hit_reg;
   logic [IDX_W-1:0]      rslt_idx_reg;

   always_ff @(posedge sysmap_clk or posedge cpurst) begin
      if (cpurst) begin
         rdata_reg     <= '0;
         rd_done_reg   <= 1'b0;
         wr_err_reg    <= 1'b0;
         rslt_vld_reg  <= 1'b0;
         rslt_attr_reg <= '0;
         rslt_hit_reg  <= 1'b0;
         rslt_idx_reg  <= '0;
      end else begin
         rd_done_reg  <= busif_rd_vld;
         wr_err_reg   <= wr_err_next;
         rslt_vld_reg <= lookup_vld;
         if (busif_rd_vld) rdata_reg <= rdata_next;
         if (lookup_vld) begin
            rslt_attr_reg <= attr_next;
            rslt_hit_reg  <= hit_next;
            rslt_idx_reg  <= idx_next;
         end
      end
   end

   assign busif_rdata      = rdata_reg;
   assign busif_rd_done    = rd_done_reg;
   assign busif_wr_err     = wr_err_reg;
   assign lookup_rslt_vld  = rslt_vld_reg;
   assign lookup_rslt_attr = rslt_attr_reg;
   assign lookup_rslt_hit  = rslt_hit_reg;
   assign lookup_rslt_idx  = rslt_idx_reg;

endmodule

// File: tb/tb_pa_sysmap_regs_nch.sv
// Directed bench for pa_sysmap_regs_nch with six regions, so that indices
// 6 and 7 exercise the out-of-range paths.
module tb_pa_sysmap_regs_nch;
   import pa_sysmap_pkg::*;

   localparam int N  = 6;
   localparam int AW = 20;
   localparam int TW = 3;
   localparam int IW = 3;
   localparam logic [TW-1:0] DFLT = 3'b010;

   logic            sysmap_clk;
   logic            cpurst;
   logic            ifu_sysmap_rst_sample;
   logic [N*AW-1:0] pad_cpu_sysmap_addr;
   logic [N*TW-1:0] pad_cpu_sysmap_attr;
   logic            busif_wr_vld;
   logic [IW-1:0]   busif_wr_idx;
   logic            busif_wr_sel;
   logic [31:0]     busif_wdata;
   logic            busif_rd_vld;
   logic [IW-1:0]   busif_rd_idx;
   logic            busif_rd_sel;
   logic [31:0]     busif_rdata;
   logic            busif_rd_done;
   logic            busif_wr_err;
   logic            lookup_vld;
   logic [AW-1:0]   lookup_addr;
   logic            lookup_rslt_vld;
   logic [TW-1:0]   lookup_rslt_attr;
   logic            lookup_rslt_hit;
   logic [IW-1:0]   lookup_rslt_idx;
   logic [N*AW-1:0] sysmap_base_addr_value;
   logic [N*5-1:0]  sysmap_flg_value;

   pa_sysmap_regs_nch #(
      .NUM_REGION (N),
      .ADDR_WIDTH (AW),
      .ATTR_WIDTH (TW),
      .DFLT_ATTR  (DFLT)
   ) dut (
      .sysmap_clk             (sysmap_clk),
      .cpurst                 (cpurst),
      .ifu_sysmap_rst_sample  (ifu_sysmap_rst_sample),
      .pad_cpu_sysmap_addr    (pad_cpu_sysmap_addr),
      .pad_cpu_sysmap_attr    (pad_cpu_sysmap_attr),
      .busif_wr_vld           (busif_wr_vld),
      .busif_wr_idx           (busif_wr_idx),
      .busif_wr_sel           (busif_wr_sel),
      .busif_wdata            (busif_wdata),
      .busif_rd_vld           (busif_rd_vld),
      .busif_rd_idx           (busif_rd_idx),
      .busif_rd_sel           (busif_rd_sel),
      .busif_rdata            (busif_rdata),
      .busif_rd_done          (busif_rd_done),
      .busif_wr_err           (busif_wr_err),
      .lookup_vld             (lookup_vld),
      .lookup_addr            (lookup_addr),
      .lookup_rslt_vld        (lookup_rslt_vld),
      .lookup_rslt_attr       (lookup_rslt_attr),
      .lookup_rslt_hit        (lookup_rslt_hit),
      .lookup_rslt_idx        (lookup_rslt_idx),
      .sysmap_base_addr_value (sysmap_base_addr_value),
      .sysmap_flg_value       (sysmap_flg_value)
   );

   initial sysmap_clk = 1'b0;
   always #5 sysmap_clk = ~sysmap_clk;

   int errors = 0;
   int checks = 0;

   logic [AW-1:0]  pad_a [N];
   logic [TW-1:0]  pad_t [N];
   sysmap_region_t exp_r [N];

   function automatic logic [N*AW-1:0] exp_base_vec();
      logic [N*AW-1:0] v;
      for (int i = 0; i < N; i++) v[i*AW +: AW] = exp_r[i].base;
      return v;
   endfunction

   function automatic logic [N*5-1:0] exp_flg_vec();
      logic [N*5-1:0] v;
      for (int i = 0; i < N; i++) v[i*5 +: 5] = {exp_r[i].attr, 2'b00};
      return v;
   endfunction

   task automatic load_exp_from_pads();
      for (int i = 0; i < N; i++) exp_r[i] = '{base: pad_a[i], attr: pad_t[i], lock: 1'b0};
   endtask

   task automatic tick();
      @(posedge sysmap_clk);
      #1;
   endtask

   task automatic idle();
      ifu_sysmap_rst_sample = 1'b0;
      busif_wr_vld = 1'b0;
      busif_wr_idx = '0;
      busif_wr_sel = SEL_BASE;
      busif_wdata  = '0;
      busif_rd_vld = 1'b0;
      busif_rd_idx = '0;
      busif_rd_sel = SEL_BASE;
      lookup_vld   = 1'b0;
      lookup_addr  = '0;
   endtask

   task automatic test_reset();
      cpurst = 1'b1;
      idle();
      tick();
      tick();
      checks += 9;
      if (busif_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", busif_rdata); end
      if (busif_rd_done !== 1'b0) begin errors++; $display("FAIL reset_rd_done: got %b expected 0", busif_rd_done); end
      if (busif_wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err: got %b expected 0", busif_wr_err); end
      if (lookup_rslt_vld !== 1'b0) begin errors++; $display("FAIL reset_rslt_vld: got %b expected 0", lookup_rslt_vld); end
      if (lookup_rslt_attr !== 3'b000) begin errors++; $display("FAIL reset_rslt_attr: got %b expected 000", lookup_rslt_attr); end
      if (lookup_rslt_hit !== 1'b0) begin errors++; $display("FAIL reset_rslt_hit: got %b expected 0", lookup_rslt_hit); end
      if (lookup_rslt_idx !== 3'd0) begin errors++; $display("FAIL reset_rslt_idx: got %0d expected 0", lookup_rslt_idx); end
      if (sysmap_base_addr_value !== '0) begin errors++; $display("FAIL reset_base: got %h expected 0", sysmap_base_addr_value); end
      if (sysmap_flg_value !== '0) begin errors++; $display("FAIL reset_flg: got %h expected 0", sysmap_flg_value); end
      cpurst = 1'b0;
      tick();
      $display("reset: outputs checked");
   endtask

   task automatic test_sample();
      ifu_sysmap_rst_sample = 1'b1;
      tick();
      ifu_sysmap_rst_sample = 1'b0;
      load_exp_from_pads();
      checks += 4;
      if (sysmap_flg_value[4:0] !== 5'b10100) begin errors++; $display("FAIL sample_flg0: got %b expected 10100", sysmap_flg_value[4:0]); end
      if (sysmap_base_addr_value[19:0] !== 20'h00010) begin errors++; $display("FAIL sample_base0: got %h expected 00010", sysmap_base_addr_value[19:0]); end
      if (sysmap_base_addr_value !== exp_base_vec()) begin errors++; $display("FAIL sample_base_all: got %h expected %h", sysmap_base_addr_value, exp_base_vec()); end
      if (sysmap_flg_value !== exp_flg_vec()) begin errors++; $display("FAIL sample_flg_all: got %h expected %h", sysmap_flg_value, exp_flg_vec()); end
      busif_rd_vld = 1'b1; busif_rd_idx = 3'd0; busif_rd_sel = SEL_FLG;
      tick();
      busif_rd_vld = 1'b0;
      checks += 2;
      if (busif_rd_done !== 1'b1) begin errors++; $display("FAIL sample_rd_done: got %b expected 1", busif_rd_done); end
      if (busif_rdata !== 32'h14) begin errors++; $display("FAIL sample_lock_clear: got %h expected 00000014", busif_rdata); end
      $display("sample: region0 base=%h flg=%b", sysmap_base_addr_value[19:0], sysmap_flg_value[4:0]);
   endtask

   task automatic test_lock();
      busif_wr_vld = 1'b1; busif_wr_idx = 3'd2; busif_wr_sel = SEL_FLG; busif_wdata = 32'h94;
      tick();
      busif_wr_vld = 1'b0;
      exp_r[2].attr = 3'b101; exp_r[2].lock = 1'b1;
      checks += 2;
      if (sysmap_flg_value[14:10] !== 5'b10100) begin errors++; $display("FAIL lock_flg2: got %b expected 10100", sysmap_flg_value[14:10]); end
      if (busif_wr_err !== 1'b0) begin errors++; $display("FAIL lock_set_err: got %b expected 0", busif_wr_err); end
      busif_rd_vld = 1'b1; busif_rd_idx = 3'd2; busif_rd_sel = SEL_FLG;
      tick();
      busif_rd_vld = 1'b0;
      checks++;
      if (busif_rdata !== 32'h94) begin errors++; $display("FAIL lock_read: got %h expected 00000094", busif_rdata); end
      busif_wr_vld = 1'b1; busif_wr_idx = 3'd2; busif_wr_sel = SEL_BASE; busif_wdata = 32'h12345;
      tick();
      busif_wr_vld = 1'b0;
      checks += 2;
      if (busif_wr_err !== 1'b1) begin errors++; $display("FAIL locked_wr_err: got %b expected 1", busif_wr_err); end
      if (sysmap_base_addr_value[59:40] !== 20'h00030) begin errors++; $display("FAIL locked_base: got %h expected 00030", sysmap_base_addr_value[59:40]); end
      tick();
      checks++;
      if (busif_wr_err !== 1'b0) begin errors++; $display("FAIL locked_err_pulse: got %b expected 0", busif_wr_err); end
      busif_wr_vld = 1'b1; busif_wr_idx = 3'd6; busif_wr_sel = SEL_BASE; busif_wdata = 32'h00777;
      tick();
      busif_wr_vld = 1'b0;
      checks += 2;
      if (busif_wr_err !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b expected 1", busif_wr_err); end
      if (sysmap_base_addr_value !== exp_base_vec()) begin errors++; $display("FAIL oor_base: got %h expected %h", sysmap_base_addr_value, exp_base_vec()); end
      ifu_sysmap_rst_sample = 1'b1;
      tick();
      ifu_sysmap_rst_sample = 1'b0;
      load_exp_from_pads();
      busif_rd_vld = 1'b1; busif_rd_idx = 3'd2; busif_rd_sel = SEL_FLG;
      tick();
      busif_rd_vld = 1'b0;
      checks++;
      if (busif_rdata !== 32'h08) begin errors++; $display("FAIL lock_cleared: got %h expected 00000008", busif_rdata); end
      $display("lock: region2 locked, rejected, unlocked by sample");
   endtask

   task automatic test_lookup();
      logic [AW-1:0] la [6];
      logic          lh [6];
      logic [IW-1:0] li [6];
      logic [TW-1:0] lt [6];
      for (int i = 0; i < N; i++) begin
         busif_wr_vld = 1'b1; busif_wr_idx = IW'(i); busif_wr_sel = SEL_BASE;
         busif_wdata = 32'((i + 1) * 32'h100);
         exp_r[i].base = AW'((i + 1) * 32'h100);
         tick();
      end
      busif_wr_vld = 1'b0;
      checks++;
      if (sysmap_base_addr_value !== exp_base_vec()) begin errors++; $display("FAIL lookup_bases: got %h expected %h", sysmap_base_addr_value, exp_base_vec()); end
      la = '{20'h001FF, 20'hFFFFF, 20'h000FF, 20'h00100, 20'h00600, 20'h005FF};
      lh = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      li = '{3'd1, 3'd0, 3'd0, 3'd1, 3'd0, 3'd5};
      lt = '{3'b001, DFLT, 3'b101, 3'b001, DFLT, 3'b110};
      for (int k = 0; k < 6; k++) begin
         lookup_vld = 1'b1; lookup_addr = la[k];
         tick();
         checks++;
         if (lookup_rslt_vld !== 1'b1 || lookup_rslt_hit !== lh[k] ||
             lookup_rslt_idx !== li[k] || lookup_rslt_attr !== lt[k]) begin
            errors++;
            $display("FAIL lookup_%h: got vld=%b hit=%b idx=%0d attr=%b expected vld=1 hit=%b idx=%0d attr=%b",
                     la[k], lookup_rslt_vld, lookup_rslt_hit, lookup_rslt_idx, lookup_rslt_attr, lh[k], li[k], lt[k]);
         end
         $display("lookup addr=%h hit=%b idx=%0d attr=%b", la[k], lookup_rslt_hit, lookup_rslt_idx, lookup_rslt_attr);
      end
      lookup_vld = 1'b0; lookup_addr = 20'h00000;
      tick();
      checks++;
      if (lookup_rslt_vld !== 1'b0 || lookup_rslt_hit !== 1'b1 ||
          lookup_rslt_idx !== 3'd5 || lookup_rslt_attr !== 3'b110) begin
         errors++;
         $display("FAIL lookup_hold: got vld=%b hit=%b idx=%0d attr=%b expected vld=0 hit=1 idx=5 attr=110",
                  lookup_rslt_vld, lookup_rslt_hit, lookup_rslt_idx, lookup_rslt_attr);
      end
   endtask

   task automatic test_simultaneous();
      busif_wr_vld = 1'b1; busif_wr_idx = 3'd0; busif_wr_sel = SEL_BASE; busif_wdata = 32'h50;
      lookup_vld = 1'b1; lookup_addr = 20'h00060;
      tick();
      busif_wr_vld = 1'b0;
      checks += 2;
      if (lookup_rslt_hit !== 1'b1 || lookup_rslt_idx !== 3'd0 || lookup_rslt_attr !== 3'b101) begin
         errors++;
         $display("FAIL simul_old_state: got hit=%b idx=%0d attr=%b expected hit=1 idx=0 attr=101", lookup_rslt_hit, lookup_rslt_idx, lookup_rslt_attr);
      end
      if (sysmap_base_addr_value[19:0] !== 20'h00050) begin errors++; $display("FAIL simul_base0: got %h expected 00050", sysmap_base_addr_value[19:0]); end
      tick();
      checks++;
      if (lookup_rslt_hit !== 1'b1 || lookup_rslt_idx !== 3'd1 || lookup_rslt_attr !== 3'b001) begin
         errors++;
         $display("FAIL simul_new_state: got hit=%b idx=%0d attr=%b expected hit=1 idx=1 attr=001", lookup_rslt_hit, lookup_rslt_idx, lookup_rslt_attr);
      end
      lookup_vld = 1'b0;
      busif_wr_vld = 1'b1; busif_wr_idx = 3'd0; busif_wr_sel = SEL_BASE; busif_wdata = 32'h0;
      tick();
      busif_wr_vld = 1'b0;
      lookup_vld = 1'b1; lookup_addr = 20'h00000;
      tick();
      lookup_vld = 1'b0;
      checks++;
      if (lookup_rslt_hit !== 1'b1 || lookup_rslt_idx !== 3'd1) begin
         errors++;
         $display("FAIL zero_base_nohit: got hit=%b idx=%0d expected hit=1 idx=1", lookup_rslt_hit, lookup_rslt_idx);
      end
      $display("simultaneous: write+lookup used old state");
   endtask

   task automatic test_sample_write();
      ifu_sysmap_rst_sample = 1'b1;
      busif_wr_vld = 1'b1; busif_wr_idx = 3'd3; busif_wr_sel = SEL_BASE; busif_wdata = 32'hABCDE;
      tick();
      ifu_sysmap_rst_sample = 1'b0;
      busif_wr_vld = 1'b0;
      load_exp_from_pads();
      checks += 3;
      if (sysmap_base_addr_value[79:60] !== 20'h00040) begin errors++; $display("FAIL samplewr_base3: got %h expected 00040", sysmap_base_addr_value[79:60]); end
      if (busif_wr_err !== 1'b0) begin errors++; $display("FAIL samplewr_err: got %b expected 0", busif_wr_err); end
      if (sysmap_base_addr_value !== exp_base_vec()) begin errors++; $display("FAIL samplewr_all: got %h expected %h", sysmap_base_addr_value, exp_base_vec()); end
      $display("sample+write: pad value kept in region3");
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_d;
      logic [IW-1:0] ix;
      for (int k = 0; k < 16; k++) begin
         ix = (k < 8) ? IW'(k) : IW'(15 - k);
         busif_rd_vld = 1'b1; busif_rd_idx = ix;
         busif_rd_sel = (k < 8) ? SEL_FLG : SEL_BASE;
         if (ix >= 3'(N)) exp_d = 32'h0;
         else if (k < 8) exp_d = 32'({pad_t[ix], 2'b00});
         else exp_d = 32'(pad_a[ix]);
         tick();
         checks++;
         if (busif_rd_done !== 1'b1 || busif_rdata !== exp_d) begin
            errors++;
            $display("FAIL b2b_read_%0d: got done=%b data=%h expected done=1 data=%h", k, busif_rd_done, busif_rdata, exp_d);
         end
         $display("read sel=%b idx=%0d data=%h", busif_rd_sel, ix, busif_rdata);
      end
      busif_rd_vld = 1'b0;
      tick();
      checks++;
      if (busif_rd_done !== 1'b0 || busif_rdata !== 32'h10) begin
         errors++;
         $display("FAIL b2b_hold: got done=%b data=%h expected done=0 data=00000010", busif_rd_done, busif_rdata);
      end
   endtask

   task automatic test_reset_mid();
      busif_rd_vld = 1'b1; busif_rd_idx = 3'd1; busif_rd_sel = SEL_BASE;
      lookup_vld = 1'b1; lookup_addr = 20'h00000;
      tick();
      checks++;
      if (busif_rd_done !== 1'b1 || lookup_rslt_vld !== 1'b1 || lookup_rslt_attr !== 3'b101) begin
         errors++;
         $display("FAIL mid_pre: got done=%b vld=%b attr=%b expected done=1 vld=1 attr=101", busif_rd_done, lookup_rslt_vld, lookup_rslt_attr);
      end
      cpurst = 1'b1;
      #1;
      checks++;
      if (busif_rdata !== 32'h0 || busif_rd_done !== 1'b0 || busif_wr_err !== 1'b0 ||
          lookup_rslt_vld !== 1'b0 || lookup_rslt_attr !== 3'b000 || lookup_rslt_hit !== 1'b0 ||
          lookup_rslt_idx !== 3'd0 || sysmap_base_addr_value !== '0 || sysmap_flg_value !== '0) begin
         errors++;
         $display("FAIL mid_reset_async: got rdata=%h done=%b vld=%b attr=%b hit=%b base=%h expected all zero",
                  busif_rdata, busif_rd_done, lookup_rslt_vld, lookup_rslt_attr, lookup_rslt_hit, sysmap_base_addr_value);
      end
      tick();
      checks++;
      if (lookup_rslt_vld !== 1'b0 || busif_rd_done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_held: got vld=%b done=%b expected 0 0", lookup_rslt_vld, busif_rd_done);
      end
      idle();
      cpurst = 1'b0;
      tick();
      $display("reset mid-stream: outputs cleared");
   endtask

   initial begin
      pad_t = '{3'b101, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110};
      for (int i = 0; i < N; i++) begin
         pad_a[i] = AW'((i + 1) * 16);
         pad_cpu_sysmap_addr[i*AW +: AW] = pad_a[i];
         pad_cpu_sysmap_attr[i*TW +: TW] = pad_t[i];
      end
      test_reset();
      test_sample();
      test_lock();
      test_lookup();
      test_simultaneous();
      test_sample_write();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
